spi_master_core: RTL and testbench

Synthesizable SPI master that drives the SPI bus consumed by the team's SPI slave model and by external SPI devices. It accepts one DWIDTH-bit word per transaction over a valid/ready interface and serializes it MSB-first on mosi. It simultaneously captures miso into a parallel word, returned with a one-cycle valid pulse. Runtime-selectable CPOL/CPHA and SCLK divider; chip select is active-high, matching the slave model.

---
 rtl/spi_master_core.sv | 112 +++++++++++
 tb/tb_spi_master_core.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_core.sv
// SPI master: one DWIDTH-bit MSB-first word per cs window, runtime CPOL/CPHA/divider; rx_valid fires
// (2*DWIDTH+1)*(clk_div+1) cycles after accept; tx_ready low while busy, requests are not queued.
module spi_master_core #(
  parameter int DWIDTH    = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DWIDTH-1:0]    tx_data,
  output logic                 rx_valid,
  output logic [DWIDTH-1:0]    rx_data,
  output logic                 busy,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso,
  output logic                 cs
);

  localparam int ECW = $clog2(2 * DWIDTH);
  localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DWIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  timer_q, div_q;
  logic                  cpha_q;
  logic [DWIDTH-1:0]     tx_sh_q, rx_sh_q;
  logic [ECW-1:0]        edge_q;
  logic                  accept, tick, edge_fire, leading, last_edge;

  assign tx_ready  = rst_b & (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = tx_valid & (state_q == IDLE);
  assign tick      = (timer_q == '0);
  // The half-period that ends SETUP produces edge 0, so cs spans 2*DWIDTH+1 half-periods.
  assign edge_fire = tick & ((state_q == SETUP) | (state_q == XFER));
  assign leading   = ~edge_q[0];
  assign last_edge = (edge_q == LAST_EDGE);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)            state_d = SETUP;
      SETUP:   if (tick)              state_d = XFER;
      XFER:    if (tick && last_edge) state_d = HOLD;
      HOLD:    if (tick)              state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      timer_q  <= '0;
      div_q    <= '0;
      cpha_q   <= 1'b0;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      edge_q   <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs       <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state_q == IDLE) begin
        sclk    <= cpol;
        mosi    <= 1'b0;
        edge_q  <= '0;
        timer_q <= clk_div;
        if (accept) begin
          cs      <= 1'b1;
          div_q   <= clk_div;
          cpha_q  <= cpha;
          rx_sh_q <= '0;
          // CPHA=0 presents the MSB before the first edge; CPHA=1 drives it on edge 0.
          mosi    <= ~cpha & tx_data[DWIDTH-1];
          tx_sh_q <= cpha ? tx_data : (tx_data << 1);
        end
      end else begin
        timer_q <= tick ? div_q : (timer_q - 1'b1);
        if (edge_fire) begin
          sclk   <= ~sclk;
          edge_q <= edge_q + 1'b1;
          if (leading ^ cpha_q) begin
            rx_sh_q <= {rx_sh_q[DWIDTH-2:0], miso};
          end else if (!last_edge) begin
            mosi    <= tx_sh_q[DWIDTH-1];
            tx_sh_q <= tx_sh_q << 1;
          end
        end
        if ((state_q == HOLD) && tick) begin
          cs       <= 1'b0;
          mosi     <= 1'b0;
          rx_data  <= rx_sh_q;
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: behavioural SPI slave plus spec-level expectations for timing and data.
module tb_spi_master_core;
  localparam int DW = 8;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          rst_b = 1'b1;
  logic          cpol = 1'b0, cpha = 1'b0;
  logic [VW-1:0] clk_div = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] tx_data = '0;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          busy, sclk, mosi, cs;
  logic          miso = 1'b0;

  int tests = 0;
  int fails = 0;

  spi_master_core #(.DWIDTH(DW), .DIV_WIDTH(VW)) dut (
    .clk(clk), .rst_b(rst_b), .cpol(cpol), .cpha(cpha), .clk_div(clk_div),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs(cs)
  );

  always #5 clk = ~clk;

  // Behavioural slave: shifts slv_tx out on miso and collects mosi, per the agreed CPOL/CPHA.
  bit            m_cpol, m_cpha;
  logic [DW-1:0] slv_tx = '0, slv_sh = '0, slv_in = '0, slv_last = '0;
  logic [DW-1:0] slv_q[$];
  int            n_edges = 0, n_rises = 0, per_min = 0, per_max = 0, rxv_total = 0;
  bit            have_rise = 0;
  time           last_rise = 0;

  always @(posedge cs) begin
    slv_sh = slv_tx;
    slv_in = '0;
    if (!m_cpha) begin
      miso   = slv_sh[DW-1];
      slv_sh = slv_sh << 1;
    end
  end

  always @(negedge cs) begin
    slv_last = slv_in;
    slv_q.push_back(slv_in);
  end

  always @(sclk) if (cs === 1'b1) begin
    n_edges++;
    if ((sclk !== m_cpol) ^ m_cpha) slv_in = {slv_in[DW-2:0], mosi};
    else begin
      miso   = slv_sh[DW-1];
      slv_sh = slv_sh << 1;
    end
  end

  always @(posedge sclk) if (cs === 1'b1) begin
    n_rises++;
    if (have_rise) begin
      if (int'($time - last_rise) < per_min) per_min = int'($time - last_rise);
      if (int'($time - last_rise) > per_max) per_max = int'($time - last_rise);
    end
    have_rise = 1;
    last_rise = $time;
  end

  always @(negedge clk) if (rx_valid === 1'b1) rxv_total++;

  function automatic int exp_cs(input int div);
    return (2 * DW + 1) * (div + 1);
  endfunction

  task automatic run_xfer(input logic [DW-1:0] d, input logic [DW-1:0] sw, input bit pol,
                          input bit pha, input logic [VW-1:0] div, input bit disturb,
                          output logic [DW-1:0] got_rx, output int cs_cyc,
                          output bit tmo, output bit rdy_bad);
    int  k;
    bit  done;
    tmo = 0; rdy_bad = 0; cs_cyc = 0; got_rx = 'x; done = 0;
    k = 0;
    while (tx_ready !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
    if (tx_ready !== 1'b1) tmo = 1;
    @(negedge clk);
    cpol = pol; cpha = pha; clk_div = div;
    m_cpol = pol; m_cpha = pha; slv_tx = sw;
    @(negedge clk);
    n_edges = 0; n_rises = 0; have_rise = 0; per_min = 1000000; per_max = 0;
    tx_data = d; tx_valid = 1'b1;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clk);
      if (i == 0) tx_valid = 1'b0;
      if (cs === 1'b1) cs_cyc++;
      if (cs === 1'b1 && tx_ready !== 1'b0) rdy_bad = 1;
      if (disturb && i == 10) begin cpol = ~pol; clk_div = 8'd7; tx_data = ~d; tx_valid = 1'b1; end
      if (disturb && i == 20) tx_valid = 1'b0;
      if (rx_valid === 1'b1) begin got_rx = rx_data; done = 1; end
    end
    if (!done) tmo = 1;
  endtask

  task automatic test_reset;
    #1 rst_b = 1'b0;
    #2;
    tests++; if (sclk !== 1'b0)     begin fails++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
    tests++; if (mosi !== 1'b0)     begin fails++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
    tests++; if (cs !== 1'b0)       begin fails++; $display("FAIL reset_cs got=%b exp=0", cs); end
    tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL reset_tx_ready got=%b exp=0", tx_ready); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    tests++; if (rx_data !== '0)    begin fails++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL post_reset_tx_ready got=%b exp=1", tx_ready); end
  endtask

  task automatic test_mode0;
    logic [DW-1:0] r; int c; bit t, rb; int rx0;
    rx0 = rxv_total;
    run_xfer(8'hA5, 8'h3C, 0, 0, 8'd1, 0, r, c, t, rb);
    repeat (4) @(negedge clk);
    tests++; if (t)               begin fails++; $display("FAIL m0_timeout got=1 exp=0"); end
    tests++; if (r !== 8'h3C)     begin fails++; $display("FAIL m0_rx got=%h exp=3c", r); end
    tests++; if (slv_last !== 8'hA5) begin fails++; $display("FAIL m0_slave got=%h exp=a5", slv_last); end
    tests++; if (c != exp_cs(1))  begin fails++; $display("FAIL m0_cs_cycles got=%0d exp=%0d", c, exp_cs(1)); end
    tests++; if (n_rises != DW)   begin fails++; $display("FAIL m0_rises got=%0d exp=%0d", n_rises, DW); end
    tests++; if (rxv_total - rx0 != 1) begin fails++; $display("FAIL m0_rx_pulses got=%0d exp=1", rxv_total - rx0); end
    tests++; if (rx_data !== 8'h3C) begin fails++; $display("FAIL m0_rx_hold got=%h exp=3c", rx_data); end
  endtask

  task automatic test_mode3;
    logic [DW-1:0] r; int c; bit t, rb;
    run_xfer(8'h81, 8'hF0, 1, 1, 8'd3, 0, r, c, t, rb);
    repeat (3) @(negedge clk);
    tests++; if (t)               begin fails++; $display("FAIL m3_timeout got=1 exp=0"); end
    tests++; if (r !== 8'hF0)     begin fails++; $display("FAIL m3_rx got=%h exp=f0", r); end
    tests++; if (slv_last !== 8'h81) begin fails++; $display("FAIL m3_slave got=%h exp=81", slv_last); end
    tests++; if (c != exp_cs(3))  begin fails++; $display("FAIL m3_cs_cycles got=%0d exp=%0d", c, exp_cs(3)); end
    tests++; if (n_edges != 2*DW) begin fails++; $display("FAIL m3_edges got=%0d exp=%0d", n_edges, 2*DW); end
    tests++; if (sclk !== 1'b1)   begin fails++; $display("FAIL m3_sclk_idle got=%b exp=1", sclk); end
  endtask

  task automatic test_modes12;
    logic [DW-1:0] r; int c; bit t, rb;
    logic [DW-1:0] dv[2] = '{8'h5A, 8'hC3};
    logic [DW-1:0] sv[2] = '{8'hA6, 8'h1E};
    for (int m = 0; m < 2; m++) begin
      run_xfer(dv[m], sv[m], m[0], ~m[0], 8'd0, 0, r, c, t, rb);
      repeat (2) @(negedge clk);
      tests++; if (t || r !== sv[m]) begin fails++; $display("FAIL m12_rx mode%0d got=%h exp=%h", m + 1, r, sv[m]); end
      tests++; if (slv_last !== dv[m]) begin fails++; $display("FAIL m12_slave mode%0d got=%h exp=%h", m + 1, slv_last, dv[m]); end
      tests++; if (c != exp_cs(0)) begin fails++; $display("FAIL m12_cs_cycles got=%0d exp=%0d", c, exp_cs(0)); end
      tests++; if (per_min != 20 || per_max != 20)
        begin fails++; $display("FAIL m12_sclk_period got=%0d..%0d exp=20", per_min, per_max); end
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] acc_q[$];
    int acc, lows, nrx, rx0;
    bit pending, seen_cs, rx_ok;
    @(negedge clk);
    cpol = 0; cpha = 0; clk_div = 8'd1; m_cpol = 0; m_cpha = 0; slv_tx = 8'h96;
    @(negedge clk);
    slv_q.delete();
    rx0 = rxv_total; acc = 0; lows = 0; nrx = 0; pending = 0; seen_cs = 0; rx_ok = 1;
    tx_data = 8'h00; tx_valid = 1'b1;
    for (int i = 0; i < 2000 && nrx < 4; i++) begin
      if (pending) begin
        tx_data = DW'(acc);
        if (acc == 4) tx_valid = 1'b0;
      end
      pending = (tx_valid === 1'b1) && (tx_ready === 1'b1);
      if (pending) begin acc++; acc_q.push_back(tx_data); end
      @(negedge clk);
      if (cs === 1'b1) seen_cs = 1;
      if (seen_cs && cs === 1'b0) lows++;
      if (rx_valid === 1'b1) begin nrx++; if (rx_data !== 8'h96) rx_ok = 0; end
    end
    tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (acc != 4)  begin fails++; $display("FAIL b2b_accepts got=%0d exp=4", acc); end
    tests++; if (rxv_total - rx0 != 4) begin fails++; $display("FAIL b2b_rx_pulses got=%0d exp=4", rxv_total - rx0); end
    tests++; if (lows != 4) begin fails++; $display("FAIL b2b_cs_low_cycles got=%0d exp=4", lows); end
    tests++; if (!rx_ok)    begin fails++; $display("FAIL b2b_rx_data got=bad exp=96"); end
    tests++; if (slv_q.size() != 4) begin fails++; $display("FAIL b2b_slave_count got=%0d exp=4", slv_q.size()); end
    for (int k = 0; k < 4 && k < slv_q.size(); k++) begin
      tests++; if (slv_q[k] !== DW'(k)) begin fails++; $display("FAIL b2b_slave_word%0d got=%h exp=%h", k, slv_q[k], DW'(k)); end
    end
    for (int k = 0; k < 4 && k < acc_q.size(); k++) begin
      tests++; if (acc_q[k] !== DW'(k)) begin fails++; $display("FAIL b2b_accept_word%0d got=%h exp=%h", k, acc_q[k], DW'(k)); end
    end
  endtask

  task automatic test_mid_change;
    logic [DW-1:0] r; int c; bit t, rb; int rx0;
    rx0 = rxv_total;
    run_xfer(8'h3E, 8'h71, 0, 0, 8'd1, 1, r, c, t, rb);
    repeat (6) @(negedge clk);
    tests++; if (t || r !== 8'h71) begin fails++; $display("FAIL mid_rx got=%h exp=71", r); end
    tests++; if (slv_last !== 8'h3E) begin fails++; $display("FAIL mid_slave got=%h exp=3e", slv_last); end
    tests++; if (c != exp_cs(1))   begin fails++; $display("FAIL mid_cs_cycles got=%0d exp=%0d", c, exp_cs(1)); end
    tests++; if (rb)               begin fails++; $display("FAIL mid_tx_ready got=1 exp=0"); end
    tests++; if (rxv_total - rx0 != 1) begin fails++; $display("FAIL mid_rx_pulses got=%0d exp=1", rxv_total - rx0); end
    cpol = 1'b0; clk_div = 8'd1;
  endtask

  task automatic test_reset_abort;
    logic [DW-1:0] r; int c; bit t, rb; int rx0, k;
    @(negedge clk);
    cpol = 0; cpha = 0; clk_div = 8'd3; m_cpol = 0; m_cpha = 0; slv_tx = 8'h55;
    @(negedge clk);
    n_edges = 0; tx_data = 8'hE7; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    k = 0;
    while (n_edges < 5 && k < 500) begin @(negedge clk); k++; end
    tests++; if (n_edges < 5) begin fails++; $display("FAIL abort_reach_edge5 got=%0d exp=5", n_edges); end
    rx0 = rxv_total;
    #2 rst_b = 1'b0;
    #1;
    tests++; if (cs !== 1'b0 || sclk !== 1'b0 || mosi !== 1'b0)
      begin fails++; $display("FAIL abort_outputs got=cs%b sclk%b mosi%b exp=000", cs, sclk, mosi); end
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL abort_tx_ready got=%b exp=1", tx_ready); end
    tests++; if (rxv_total != rx0)  begin fails++; $display("FAIL abort_rx_pulses got=%0d exp=0", rxv_total - rx0); end
    run_xfer(8'h99, 8'h24, 0, 0, 8'd2, 0, r, c, t, rb);
    @(negedge clk);
    tests++; if (t || r !== 8'h24) begin fails++; $display("FAIL abort_next_rx got=%h exp=24", r); end
    tests++; if (slv_last !== 8'h99) begin fails++; $display("FAIL abort_next_slave got=%h exp=99", slv_last); end
    tests++; if (c != exp_cs(2)) begin fails++; $display("FAIL abort_next_cs got=%0d exp=%0d", c, exp_cs(2)); end
  endtask

  task automatic test_random;
    logic [DW-1:0] r, d, sw; int c; bit t, rb, pol, pha; logic [VW-1:0] div;
    for (int n = 0; n < 12; n++) begin
      pol = 1'($urandom_range(0, 1)); pha = 1'($urandom_range(0, 1));
      div = VW'($urandom_range(0, 3)); d = DW'($urandom); sw = DW'($urandom);
      run_xfer(d, sw, pol, pha, div, 0, r, c, t, rb);
      @(negedge clk);
      tests++; if (t || r !== sw) begin fails++; $display("FAIL rnd%0d_rx got=%h exp=%h", n, r, sw); end
      tests++; if (slv_last !== d) begin fails++; $display("FAIL rnd%0d_slave got=%h exp=%h", n, slv_last, d); end
      tests++; if (c != exp_cs(int'(div)) || n_edges != 2*DW)
        begin fails++; $display("FAIL rnd%0d_timing got=cs%0d/e%0d exp=cs%0d/e%0d", n, c, n_edges, exp_cs(int'(div)), 2*DW); end
    end
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_mode3;
    test_modes12;
    test_back_to_back;
    test_mid_change;
    test_reset_abort;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
